// File: rtl/fast_bridge_pkg.sv
// Shared definitions for the AXI-Stream <-> FAST UM bridge: position codes,
// framing FSM states and the statistics counter width.
package fast_bridge_pkg;

    localparam logic [1:0] POS_IDLE = 2'b00;
    localparam logic [1:0] POS_HEAD = 2'b01;
    localparam logic [1:0] POS_BODY = 2'b11;
    localparam logic [1:0] POS_TAIL = 2'b10;

    localparam int CNT_W = 32;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } fsm_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bridge_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and a free-entry
// count. DEPTH must be a power of two; writes when full and reads when empty are ignored.
module bridge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok    = wr_en & ~full;
    assign rd_ok    = rd_en & ~empty;
    assign full     = (count == DEPTH_L);
    assign empty    = (count == '0);
    assign free_cnt = DEPTH_L - count;
    assign rd_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/axis_fast_bridge.sv
// AXI-Stream <-> FAST UM pktin/pktout bridge. Define BRIDGE_STATS_EN to add the
// saturating tx_frame_cnt / rx_frame_cnt / rx_err_cnt outputs.
//   state        | meaning
//   ST_IDLE      | between frames; next beat starts a frame
//   ST_IN_FRAME  | head seen, waiting for body/tail beats
module axis_fast_bridge
    import fast_bridge_pkg::*;
#(
    parameter int DATA_WIDTH     = 256,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int TX_FIFO_DEPTH  = 16,
    parameter int TX_ALMOST_FULL = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [DATA_WIDTH-1:0] tx_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] tx_axis_tkeep,
    input  logic                  tx_axis_tvalid,
    input  logic                  tx_axis_tlast,
    output logic                  tx_axis_tready,

    output logic [DATA_WIDTH-1:0] pktin_data,
    output logic [KEEP_WIDTH-1:0] pktin_keep,
    output logic [1:0]            pktin_pos,
    output logic                  pktin_data_wr,
    output logic                  pktin_data_valid,
    input  logic                  pktin_ready,

    input  logic [DATA_WIDTH-1:0] pktout_data,
    input  logic [KEEP_WIDTH-1:0] pktout_keep,
    input  logic [1:0]            pktout_pos,
    input  logic                  pktout_data_wr,
    output logic                  pktout_ready,

    output logic [DATA_WIDTH-1:0] rx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
    output logic                  rx_axis_tvalid,
    output logic                  rx_axis_tlast,
    output logic                  rx_axis_tuser,
    input  logic                  rx_axis_tready
`ifdef BRIDGE_STATS_EN
    ,
    output logic [CNT_W-1:0]      tx_frame_cnt,
    output logic [CNT_W-1:0]      rx_frame_cnt,
    output logic [CNT_W-1:0]      rx_err_cnt
`endif
);

    localparam int ENTRY_W = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam int FREE_W  = $clog2(TX_FIFO_DEPTH) + 1;
    localparam logic [FREE_W-1:0] ALMOST_FULL_L = FREE_W'(TX_ALMOST_FULL);

    // ---------------------------------------------------------------- TX
    fsm_state_t            tx_state_q;
    fsm_state_t            tx_state_d;
    logic [1:0]            tx_tag;
    logic                  tx_accept;
    logic                  tx_push;
    logic                  tx_pop;
    logic [ENTRY_W-1:0]    fifo_wr_data;
    logic [ENTRY_W-1:0]    fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FREE_W-1:0]     fifo_free;
    logic [FREE_W-1:0]     free_nxt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [KEEP_WIDTH-1:0] rd_keep;
    logic [1:0]            rd_pos;

    assign tx_accept    = tx_axis_tvalid & tx_axis_tready;
    assign tx_push      = tx_accept & ~fifo_full;
    assign tx_pop       = ~fifo_empty & pktin_ready;
    assign fifo_wr_data = {tx_axis_tdata, tx_axis_tkeep, tx_tag};
    assign {rd_data, rd_keep, rd_pos} = fifo_rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_q <= ST_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tag     = POS_HEAD;
        if (tx_state_q == ST_IN_FRAME) tx_tag = tx_axis_tlast ? POS_TAIL : POS_BODY;
        else                           tx_tag = tx_axis_tlast ? POS_TAIL : POS_HEAD;
        if (tx_accept) tx_state_d = tx_axis_tlast ? ST_IDLE : ST_IN_FRAME;
    end

    bridge_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (tx_push),
        .wr_data  (fifo_wr_data),
        .rd_en    (tx_pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .free_cnt (fifo_free)
    );

    // Ready is registered, so it is computed from next-cycle occupancy to keep
    // the almost-full margin exact.
    always_comb begin
        free_nxt = fifo_free;
        if (tx_push && !tx_pop)      free_nxt = fifo_free - 1'b1;
        else if (!tx_push && tx_pop) free_nxt = fifo_free + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_axis_tready <= 1'b0;
        else        tx_axis_tready <= (free_nxt > ALMOST_FULL_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pktin_data       <= '0;
            pktin_keep       <= '0;
            pktin_pos        <= POS_IDLE;
            pktin_data_wr    <= 1'b0;
            pktin_data_valid <= 1'b0;
        end else begin
            pktin_data_wr    <= tx_pop;
            pktin_data_valid <= tx_pop & (rd_pos == POS_TAIL);
            if (tx_pop) begin
                pktin_data <= rd_data;
                pktin_keep <= rd_keep;
                pktin_pos  <= rd_pos;
            end
        end
    end

    // ---------------------------------------------------------------- RX
    fsm_state_t rx_state_q;
    fsm_state_t rx_state_d;
    logic       rx_fire;
    logic       rx_drop;
    logic       rx_bad_pos;

    assign pktout_ready  = rx_axis_tready;
    assign rx_axis_tdata = pktout_data;
    assign rx_axis_tkeep = pktout_keep;
    assign rx_axis_tlast = (pktout_pos == POS_TAIL);

    // A frame cannot open with body/idle; a head or idle code inside a frame
    // is passed on but flagged.
    assign rx_drop    = (rx_state_q == ST_IDLE) &
                        ((pktout_pos == POS_BODY) | (pktout_pos == POS_IDLE));
    assign rx_bad_pos = (rx_state_q == ST_IN_FRAME) &
                        ((pktout_pos == POS_HEAD) | (pktout_pos == POS_IDLE));
    assign rx_fire    = pktout_data_wr & rx_axis_tready;

    assign rx_axis_tvalid = pktout_data_wr & ~rx_drop;
    assign rx_axis_tuser  = pktout_data_wr & rx_bad_pos;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= ST_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        if (rx_fire) begin
            if (rx_state_q == ST_IDLE && pktout_pos == POS_HEAD)
                rx_state_d = ST_IN_FRAME;
            else if (rx_state_q == ST_IN_FRAME && pktout_pos == POS_TAIL)
                rx_state_d = ST_IDLE;
        end
    end

`ifdef BRIDGE_STATS_EN
    logic tx_tail_pop;
    logic rx_tail_fwd;
    logic rx_err_evt;

    assign tx_tail_pop = tx_pop & (rd_pos == POS_TAIL);
    assign rx_tail_fwd = rx_fire & ~rx_drop & (pktout_pos == POS_TAIL);
    assign rx_err_evt  = rx_fire & (rx_drop | rx_bad_pos);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_frame_cnt <= '0;
            rx_frame_cnt <= '0;
            rx_err_cnt   <= '0;
        end else begin
            if (tx_tail_pop) tx_frame_cnt <= sat_inc(tx_frame_cnt);
            if (rx_tail_fwd) rx_frame_cnt <= sat_inc(rx_frame_cnt);
            if (rx_err_evt)  rx_err_cnt   <= sat_inc(rx_err_cnt);
        end
    end
`endif

endmodule

// File: doc/axis_fast_bridge.md
Name: axis_fast_bridge

Overview:
- Parametrised bidirectional bridge between Corundum-style AXI-Stream interfaces and the FAST UM pktin/pktout interfaces.
- TX direction:
  - Buffers AXIS beats in a FIFO.
  - Tags each beat with a FAST frame-position code.
  - Honours pktin_ready backpressure.
- RX direction:
  - Rebuilds AXIS framing (tlast) from FAST position codes.
  - Checks FAST frame protocol.
- Sits between the NIC datapath and the FAST pipeline. Replaces the fixed 256-bit delay-line wrapper.

Parameters:
- DATA_WIDTH, 256, datapath width in bits (64, 128, 256 or 512).
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- TX_FIFO_DEPTH, 16, TX buffer depth in beats (power of two, at least 4).
- TX_ALMOST_FULL, 2, free-entry threshold at which tx_axis_tready deasserts.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_axis_tdata  in  DATA_WIDTH  AXIS TX data
- tx_axis_tkeep  in  KEEP_WIDTH  AXIS TX byte enables
- tx_axis_tvalid  in  1  AXIS TX valid
- tx_axis_tlast  in  1  AXIS TX end of frame
- tx_axis_tready  out  1  AXIS TX ready
- pktin_data  out  DATA_WIDTH  FAST input data
- pktin_keep  out  KEEP_WIDTH  FAST input byte enables
- pktin_pos  out  2  position code: 01 head, 11 body, 10 tail
- pktin_data_wr  out  1  beat strobe
- pktin_data_valid  out  1  frame-complete strobe, asserted on the tail beat only
- pktin_ready  in  1  FAST accepts a beat this cycle
- pktout_data  in  DATA_WIDTH  FAST output data
- pktout_keep  in  KEEP_WIDTH  FAST output byte enables
- pktout_pos  in  2  FAST output position code
- pktout_data_wr  in  1  FAST output beat strobe
- pktout_ready  out  1  bridge accepts a FAST output beat
- rx_axis_tdata  out  DATA_WIDTH  AXIS RX data
- rx_axis_tkeep  out  KEEP_WIDTH  AXIS RX byte enables
- rx_axis_tvalid  out  1  AXIS RX valid
- rx_axis_tlast  out  1  AXIS RX end of frame
- rx_axis_tuser  out  1  per-beat protocol-error flag
- rx_axis_tready  in  1  AXIS RX ready

Behaviour:
- Clocking and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset state:
  - All outputs 0, except tx_axis_tready = 1 once the FIFO is empty after reset.
  - FIFO empty, both FSMs in IDLE.
- TX tagging FSM, states IDLE and IN_FRAME:
  - A beat is accepted when tx_axis_tvalid and tx_axis_tready are both high.
  - Accepted beat in IDLE: tag 01; if tlast, tag is 10 instead (single-beat frame).
  - Accepted beat in IN_FRAME: tag 11, or 10 if tlast.
  - Transitions: IDLE→IN_FRAME on an accepted non-last beat; IN_FRAME→IDLE on an accepted tlast beat.
- TX FIFO write: pushes {data, keep, tag} on the accepted beat.
- TX ready: tx_axis_tready = (free entries > TX_ALMOST_FULL), registered.
- TX output stage (registered):
  - Fires when the FIFO is non-empty and pktin_ready is high. That cycle it pops one entry and drives pktin_data_wr = 1 with the data, keep and pos of that entry.
  - pktin_data_valid = pktin_data_wr AND (pos == 10).
  - Otherwise pktin_data_wr = 0 and pktin_data_valid = 0; data holds its last value.
- TX latency: minimum 2 cycles from accept to pktin_data_wr, with an empty FIFO and pktin_ready held high.
- Simultaneous push and pop: occupancy unchanged.
- FIFO full: cannot be overrun, because tready deasserts early. Any beat presented while tready is low is not accepted.
- RX combinational path:
  - pktout_ready = rx_axis_tready.
  - Data and keep pass straight through.
  - rx_axis_tlast = (pktout_pos == 10).
- RX protocol FSM, states IDLE and IN_FRAME; advances on pktout_data_wr AND pktout_ready:
  - IDLE: 01 → IN_FRAME, beat forwarded. 10 → forwarded, stay IDLE (single-beat frame).
  - IDLE: 11 or 00 → beat dropped (rx_axis_tvalid = 0), error event.
  - IN_FRAME: 11 → forwarded. 10 → forwarded, → IDLE.
  - IN_FRAME: 01 → forwarded with rx_axis_tuser = 1, stay IN_FRAME, error event.
  - IN_FRAME: 00 → forwarded with rx_axis_tuser = 1, error event.
- rx_axis_tvalid = pktout_data_wr AND the beat is not dropped.
- Reset asserted mid-frame: both FSMs return to IDLE and the FIFO is flushed. A partial frame is lost; downstream must tolerate this.

Optional Feature:
- BRIDGE_STATS_EN defined:
  - Adds 32-bit outputs tx_frame_cnt (increments per tail popped to FAST), rx_frame_cnt (per tail forwarded) and rx_err_cnt (per error event).
  - All three saturate at 0xFFFFFFFF and reset to 0.
- Not defined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fast_bridge_pkg:
  - Position-code constants POS_IDLE = 2'b00, POS_HEAD = 2'b01, POS_BODY = 2'b11, POS_TAIL = 2'b10.
  - FSM state enum.
  - Counter width constant.
- Sub-module: one natural sub-module, bridge_sync_fifo, a parametrised synchronous FIFO.
  - Parameters: width and depth.
  - Outputs: full, empty and free-count.
  - Instantiated once for TX.

Test Plan:
- 3-beat frame, pktin_ready = 1 → pktin_pos 01, 11, 10 on consecutive cycles; pktin_data_valid high on the third beat only; first pktin_data_wr 2 cycles after accept.
- Single-beat frame, tkeep = 0x0000000F → one pktin beat, pos 10, keep 0x0000000F, pktin_data_valid = 1.
- 40 back-to-back beats, pktin_ready held 0, TX_FIFO_DEPTH 16 → tready drops after 14 accepts; no loss or reordering once pktin_ready = 1.
- RX sequence 11 (in IDLE), then 01, 11, 10 → first beat dropped; next 3 beats forwarded with tlast on the last; rx_err_cnt = 1 (stats on).
- RX 01, 01, 10 → all 3 forwarded; second beat has tuser = 1; tlast on the third.
- rst_n pulsed low for 1 cycle mid-TX-frame with 5 entries queued → pktin_data_wr = 0 and tready = 1 after reset; next frame starts tagged 01.
